// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing, 3-5+w cycles per instruction.
// Memory stalls hold MEM until MEM_RDY; a stall of MEM_TIMEOUT cycles sets ERR and parks the FSM in HALT.
module ctrl_mc #(
  parameter int COND_W      = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        OPCODE,
  input  logic [COND_W-1:0] MM,
  input  logic [COND_W-1:0] STAT,
  input  logic              MEM_RDY,
  output logic              PC_RST,
  output logic              PC_WRITE,
  output logic              PC_SEL,
  output logic              BR_SEL,
  output logic              RF_WE,
  output logic              WB_SEL,
  output logic [1:0]        RD_SEL,
  output logic              SWAP_SEL,
  output logic [1:0]        ALU_OP,
  output logic              MM_SEL,
  output logic              DM_WE,
  output logic              DM_RE,
  output logic              HALTED,
  output logic              ERR,
  output logic [2:0]        STATE,
  output logic [CNT_W-1:0]  RETIRED
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_LOD  = 4'd1,
    OP_STR  = 4'd2,
    OP_SWAP = 4'd3,
    OP_BRA  = 4'd4,
    OP_BRR  = 4'd5,
    OP_BNE  = 4'd6,
    OP_ALU  = 4'd8,
    OP_HLT  = 4'd15
  } op_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [COND_W-1:0] MM_IMM    = COND_W'(8);
  localparam logic [COND_W-1:0] MM_IDX    = '0;

  state_t              state_q, state_d;
  op_t                 lop_q, lop_d;
  logic [COND_W-1:0]   lmm_q, lmm_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    ret_q, ret_d;

  op_t                 live_op;
  logic                cond_hit;
  logic                retire;

  function automatic op_t decode_op(input logic [3:0] raw);
    case (raw)
      4'd1:    return OP_LOD;
      4'd2:    return OP_STR;
      4'd3:    return OP_SWAP;
      4'd4:    return OP_BRA;
      4'd5:    return OP_BRR;
      4'd6:    return OP_BNE;
      4'd8:    return OP_ALU;
      4'd15:   return OP_HLT;
      default: return OP_NOOP;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    lop_d    = lop_q;
    lmm_d    = lmm_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ret_d    = ret_q;
    PC_RST   = 1'b0;
    PC_WRITE = 1'b0;
    PC_SEL   = 1'b0;
    BR_SEL   = 1'b0;
    RF_WE    = 1'b0;
    WB_SEL   = 1'b0;
    RD_SEL   = 2'd0;
    SWAP_SEL = 1'b0;
    ALU_OP   = 2'b00;
    MM_SEL   = 1'b0;
    DM_WE    = 1'b0;
    DM_RE    = 1'b0;
    HALTED   = 1'b0;

    live_op  = decode_op(OPCODE);
    cond_hit = |(lmm_q & STAT);

    case (state_q)
      S_START: begin
        PC_RST  = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        PC_WRITE = 1'b1;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        if (live_op == OP_LOD || (live_op == OP_ALU && MM == MM_IMM)) begin
          RD_SEL = 2'd1;
        end else if (live_op == OP_SWAP) begin
          RD_SEL = 2'd2;
        end
        lop_d   = live_op;
        lmm_d   = MM;
        state_d = (live_op == OP_HLT) ? S_HALT : S_EXECUTE;
      end

      S_EXECUTE: begin
        wait_d  = '0;
        state_d = S_MEM;
        case (lop_q)
          OP_ALU: ALU_OP = (lmm_q == MM_IMM) ? 2'b01 : 2'b00;
          OP_LOD, OP_STR: begin
            if (lmm_q == MM_IDX) begin
              ALU_OP = 2'b01;
            end else if (lmm_q == MM_IMM) begin
              MM_SEL = 1'b1;
            end
          end
          OP_BRA, OP_BRR, OP_BNE: begin
            ALU_OP  = 2'b10;
            state_d = S_FETCH;
            // bne inverts the sense of the masked condition
            if ((lop_q == OP_BNE) ? !cond_hit : cond_hit) begin
              PC_WRITE = 1'b1;
              PC_SEL   = 1'b1;
              BR_SEL   = (lop_q != OP_BRR);
            end
          end
          OP_SWAP: begin
            RF_WE  = 1'b1;
            ALU_OP = 2'b10;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        case (lop_q)
          OP_ALU: begin
            RF_WE   = 1'b1;
            state_d = S_FETCH;
          end
          OP_LOD, OP_STR: begin
            DM_RE = (lop_q == OP_LOD);
            DM_WE = (lop_q == OP_STR);
            // a ready in the final allowed cycle still completes the access
            if (MEM_RDY) begin
              state_d = (lop_q == OP_LOD) ? S_WB : S_FETCH;
            end else if (wait_q == WAIT_LAST) begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
          OP_SWAP: state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end

      S_WB: begin
        RF_WE    = 1'b1;
        WB_SEL   = (lop_q == OP_LOD);
        SWAP_SEL = (lop_q == OP_SWAP);
        state_d  = S_FETCH;
      end

      S_HALT: HALTED = 1'b1;

      default: state_d = S_START;
    endcase

    retire = (state_d == S_FETCH) &&
             (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB);
    if (retire && ret_q != {CNT_W{1'b1}}) begin
      ret_d = ret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_START;
      lop_q   <= OP_NOOP;
      lmm_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      lop_q   <= lop_d;
      lmm_q   <= lmm_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  assign STATE   = state_q;
  assign ERR     = err_q;
  assign RETIRED = ret_q;

endmodule
